// File: rtl/serial_multiple_tx.sv
// Parallel-to-serial stimulus transmitter: clear pulse, then MSB-first bits with
// the expected "divisible by DIVISOR" flag for the running prefix value.
module serial_multiple_tx #(
    parameter int WIDTH   = 16,
    parameter int DIVISOR = 5,
    parameter int LW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LW-1:0]    in_len,
    output logic             in_ready,
    output logic             frame_clr,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             exp_div
);
    localparam int RW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

    typedef enum logic [1:0] {IDLE, CLR, SHIFT} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [LW-1:0]    cnt_reg, cnt_next;
    logic [RW-1:0]    rem_reg, rem_next;
    logic             in_ready_reg, in_ready_next;
    logic             frame_clr_reg, frame_clr_next;
    logic             dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             dout_last_reg, dout_last_next;
    logic             exp_div_reg, exp_div_next;

    logic [LW-1:0]    len_eff;
    logic [LW-1:0]    shamt;
    logic [RW:0]      rem_sum;
    logic [RW-1:0]    rem_step;
    logic             emit;

    // Out-of-range lengths fall back to a full-width word.
    assign len_eff = ((in_len == '0) || (in_len > LW'(WIDTH))) ? LW'(WIDTH) : in_len;
    assign shamt   = LW'(WIDTH) - len_eff;

    // rem < DIVISOR, so 2*rem+bit < 2*DIVISOR and one subtraction reduces it.
    assign rem_sum  = {rem_reg, shreg_reg[WIDTH-1]};
    assign rem_step = (rem_sum >= (RW+1)'(DIVISOR)) ? RW'(rem_sum - (RW+1)'(DIVISOR))
                                                    : RW'(rem_sum);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            cnt_reg        <= '0;
            rem_reg        <= '0;
            in_ready_reg   <= 1'b0;
            frame_clr_reg  <= 1'b0;
            dout_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            exp_div_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            cnt_reg        <= cnt_next;
            rem_reg        <= rem_next;
            in_ready_reg   <= in_ready_next;
            frame_clr_reg  <= frame_clr_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            dout_last_reg  <= dout_last_next;
            exp_div_reg    <= exp_div_next;
        end
    end

    // Outputs are computed for the state being entered, so each state's
    // registered outputs are visible during that state. cnt counts bits not yet sent.
    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        cnt_next        = cnt_reg;
        rem_next        = rem_reg;
        frame_clr_next  = 1'b0;
        dout_next       = 1'b0;
        dout_valid_next = 1'b0;
        dout_last_next  = 1'b0;
        exp_div_next    = 1'b0;
        emit            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready_reg) begin
                    state_next     = CLR;
                    shreg_next     = in_data << shamt;
                    cnt_next       = len_eff;
                    rem_next       = '0;
                    frame_clr_next = 1'b1;
                end
            end
            CLR: begin
                state_next = SHIFT;
                emit       = 1'b1;
            end
            SHIFT: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               emit       = 1'b1;
            end
            default: state_next = IDLE;
        endcase

        if (emit) begin
            dout_next       = shreg_reg[WIDTH-1];
            dout_valid_next = 1'b1;
            dout_last_next  = (cnt_reg == LW'(1));
            rem_next        = rem_step;
            exp_div_next    = (rem_step == '0);
            shreg_next      = {shreg_reg[WIDTH-2:0], 1'b0};
            cnt_next        = cnt_reg - LW'(1);
        end

        in_ready_next = (state_next == IDLE);
    end

    assign in_ready   = in_ready_reg;
    assign frame_clr  = frame_clr_reg;
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign dout_last  = dout_last_reg;
    assign exp_div    = exp_div_reg;
endmodule

// File: tb/tb_serial_multiple_tx.sv
// Scoreboard bench for serial_multiple_tx: expected bit stream is derived from
// integer prefixes of each word and checked by an independent monitor.
module tb_serial_multiple_tx;
    localparam int WIDTH   = 16;
    localparam int DIVISOR = 5;
    localparam int LW      = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             resetn;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [LW-1:0]    in_len;
    logic             in_ready, frame_clr, dout, dout_valid, dout_last, exp_div;

    serial_multiple_tx #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
        .in_len(in_len), .in_ready(in_ready), .frame_clr(frame_clr), .dout(dout),
        .dout_valid(dout_valid), .dout_last(dout_last), .exp_div(exp_div)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit d;
        bit e;
        bit l;
        bit f;
    } exp_t;

    exp_t exp_q[$];
    int   xfer_cyc[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   clr_pending = 0;
    bit   mon_en = 0;
    bit   prev_clr = 0;
    bit   prev_last = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference: bit i of a frame is the LSB of the integer formed by the first
    // i+1 transmitted bits; the flag is that integer modulo DIVISOR being zero.
    function automatic void push_frame(input logic [WIDTH-1:0] d, input int len);
        int          l;
        int unsigned word, prefix;
        exp_t        e;
        l = (len == 0 || len > WIDTH) ? WIDTH : len;
        word = int'(d) & ((1 << l) - 1);
        for (int i = 0; i < l; i++) begin
            prefix = word >> (l - 1 - i);
            e.d = prefix[0];
            e.e = (prefix % DIVISOR) == 0;
            e.l = (i == l - 1);
            e.f = (i == 0);
            exp_q.push_back(e);
        end
        clr_pending++;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            prev_clr  = 0;
            prev_last = 0;
        end else if (mon_en) begin
            if (prev_last) chk("ready_after_last", in_ready, 1);
            if (frame_clr) begin
                chk("clr_expected", clr_pending > 0, 1);
                chk("clr_no_valid", dout_valid, 0);
                chk("clr_busy_ready", in_ready, 0);
                if (clr_pending > 0) clr_pending--;
            end
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] bit dout=%0d exp_div=%0d last=%0d", dout, exp_div, dout_last);
                    chk("dout", dout, e.d);
                    chk("exp_div", exp_div, e.e);
                    chk("dout_last", dout_last, e.l);
                    chk("clr_before_first", prev_clr, e.f);
                    chk("shift_busy_ready", in_ready, 0);
                end
            end else if (!frame_clr) begin
                chk("idle_outputs_zero", {29'd0, dout, exp_div, dout_last}, 0);
            end
            prev_clr  = frame_clr;
            prev_last = dout_valid && dout_last;
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input int len, input bit keep);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = LW'(len);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("handshake_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        $display("[TB] send data=%04h len=%0d at cycle %0d", d, len, cyc);
        xfer_cyc.push_back(cyc);
        push_frame(d, len);
        @(posedge clk);
        if (!keep) begin
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || clr_pending != 0) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_queue_empty", exp_q.size() + clr_pending, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_frame_clr"}, frame_clr, 0);
        chk({tag, "_dout_valid"}, dout_valid, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_dout_last"}, dout_last, 0);
        chk({tag, "_exp_div"}, exp_div, 0);
    endtask

    initial begin
        int n;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_len   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("ready_first_edge", in_ready, 1);

        send(16'h0005, 3, 0);
        send(16'd10, 4, 0);
        send(16'h0000, 4, 0);
        send(16'hFFFF, 0, 0);
        drain();

        // Back-to-back with in_valid held: second accept is len+2 cycles later.
        send(16'h0006, 3, 1);
        send(16'h0002, 2, 0);
        chk("b2b_spacing", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[xfer_cyc.size()-2], 5);
        drain();

        // Abort during the second bit of an 8-bit frame.
        send(16'h00A5, 8, 0);
        n = 0;
        while (exp_q.size() > 6 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached_bit2", exp_q.size(), 6);
        #1;
        resetn = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        clr_pending = 0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", in_ready, 1);
        send(16'h0005, 3, 0);
        drain();

        for (int i = 0; i < 60; i++) begin
            send(WIDTH'($urandom), int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
